// File: rtl/can_id_hopping_scheduler_pkg.sv
// can_id_hopping_scheduler_pkg: shared widths, FSM encoding and page-step helper
package can_id_hopping_scheduler_pkg;
    localparam int ID_W = 11;
    localparam int PAGE_W = 4;
    localparam int MSG_W = 8;
    typedef enum logic [1:0] {LOAD, RUN, WAIT, HOP} state_t;
    function automatic logic [PAGE_W-1:0] next_page(input logic [PAGE_W-1:0] page, input logic [3:0] key);
        return page + (key | 4'h1);
    endfunction
endpackage

// File: rtl/can_id_hopping_scheduler_if.sv
// can_id_hopping_scheduler_if: cfg load, tx/rx lookup handshakes and table-pair bus; master = environment, slave = scheduler
interface can_id_hopping_scheduler_if;
    import can_id_hopping_scheduler_pkg::*;
    logic              cfg_valid, cfg_ready, cfg_done;
    logic [ID_W-1:0]   cfg_id;
    logic [3:0]        hop_key;
    logic              tx_req, rx_req, tx_gnt, rx_gnt;
    logic [ID_W-1:0]   tx_app_id, rx_phys_id;
    logic              tx_rsp_valid, rx_rsp_valid;
    logic [ID_W-1:0]   tx_phys_id, rx_app_id;
    logic              tbl_we, tbl_send_bit, tbl_receive_bit, page_hop;
    logic [ID_W-1:0]   tbl_id, tbl_id_o_1, tbl_id_o_2;
    logic [PAGE_W-1:0] tbl_page;
    modport master (
        output cfg_valid, cfg_id, hop_key, tx_req, tx_app_id, rx_req, rx_phys_id, tbl_id_o_1, tbl_id_o_2,
        input  cfg_ready, cfg_done, tx_gnt, rx_gnt, tx_rsp_valid, tx_phys_id, rx_rsp_valid, rx_app_id,
               tbl_we, tbl_send_bit, tbl_receive_bit, tbl_id, tbl_page, page_hop
    );
    modport slave (
        input  cfg_valid, cfg_id, hop_key, tx_req, tx_app_id, rx_req, rx_phys_id, tbl_id_o_1, tbl_id_o_2,
        output cfg_ready, cfg_done, tx_gnt, rx_gnt, tx_rsp_valid, tx_phys_id, rx_rsp_valid, rx_app_id,
               tbl_we, tbl_send_bit, tbl_receive_bit, tbl_id, tbl_page, page_hop
    );
endinterface

// File: rtl/can_id_hopping_scheduler_arbiter.sv
// can_id_hop_arbiter: two-requester round-robin (clk, rest_bit_n, en, tx_req/rx_req in; tx_gnt/rx_gnt out), priority flips to the side not granted last
module can_id_hop_arbiter (
    input  logic clk,
    input  logic rest_bit_n,
    input  logic en,
    input  logic tx_req,
    input  logic rx_req,
    output logic tx_gnt,
    output logic rx_gnt
);
    logic prio_rx;
    assign tx_gnt = en && tx_req && (!rx_req || !prio_rx);
    assign rx_gnt = en && rx_req && (!tx_req || prio_rx);
    always_ff @(posedge clk or negedge rest_bit_n) begin
        if (!rest_bit_n) prio_rx <= 1'b0;
        else if (tx_gnt || rx_gnt) prio_rx <= tx_gnt;
    end
endmodule

// File: rtl/can_id_hopping_scheduler.sv
// can_id_hopping_scheduler: loads the ID table, arbitrates tx/rx lookups, returns table results and hops the page every HOP_INTERVAL responses (clk, rest_bit_n, bus = slave modport)
module can_id_hopping_scheduler
    import can_id_hopping_scheduler_pkg::*;
#(
    parameter int NUM_IDS = 16,
    parameter int HOP_INTERVAL = 255,
    parameter int LOOKUP_LAT = 2
) (
    input logic clk,
    input logic rest_bit_n,
    can_id_hopping_scheduler_if.slave bus
);
    localparam logic [4:0] LOAD_LAST = 5'(NUM_IDS - 1);
    localparam logic [1:0] LAT = 2'(LOOKUP_LAT);
    localparam logic [MSG_W-1:0] HOP_LAST = MSG_W'(HOP_INTERVAL - 1);
    state_t            state;
    logic [4:0]        load_cnt;
    logic [MSG_W-1:0]  msg_cnt;
    logic [1:0]        wait_cnt;
    logic              side_rx, page_hop_q, tx_g, rx_g, cfg_acc, rsp;
    logic [PAGE_W-1:0] page;
    can_id_hop_arbiter u_arb (
        .clk(clk), .rest_bit_n(rest_bit_n), .en(state == RUN),
        .tx_req(bus.tx_req), .rx_req(bus.rx_req), .tx_gnt(tx_g), .rx_gnt(rx_g)
    );
    assign cfg_acc = bus.cfg_valid && bus.cfg_ready;
    assign rsp = state == WAIT && wait_cnt == LAT;
    assign bus.cfg_ready = state == LOAD && rest_bit_n;
    assign bus.cfg_done = state != LOAD;
    assign bus.tbl_we = cfg_acc;
    assign bus.tbl_send_bit = tx_g;
    assign bus.tbl_receive_bit = rx_g;
    assign bus.tx_gnt = tx_g;
    assign bus.rx_gnt = rx_g;
    assign bus.tbl_id = cfg_acc ? bus.cfg_id : tx_g ? bus.tx_app_id : rx_g ? bus.rx_phys_id : '0;
    assign bus.tx_rsp_valid = rsp && !side_rx;
    assign bus.rx_rsp_valid = rsp && side_rx;
    assign bus.tx_phys_id = bus.tx_rsp_valid ? bus.tbl_id_o_1 : '0;
    assign bus.rx_app_id = bus.rx_rsp_valid ? bus.tbl_id_o_2 : '0;
    assign bus.tbl_page = page;
    assign bus.page_hop = page_hop_q;
    // page only moves in HOP, so a lookup in WAIT always sees the page it was granted under
    always_ff @(posedge clk or negedge rest_bit_n) begin
        if (!rest_bit_n) begin
            state <= LOAD;
            load_cnt <= '0;
            msg_cnt <= '0;
            wait_cnt <= '0;
            side_rx <= 1'b0;
            page <= '0;
            page_hop_q <= 1'b0;
        end else begin
            page_hop_q <= 1'b0;
            case (state)
                LOAD: if (cfg_acc) begin
                    load_cnt <= load_cnt + 5'd1;
                    state <= load_cnt == LOAD_LAST ? RUN : LOAD;
                end
                RUN: if (tx_g || rx_g) begin
                    state <= WAIT;
                    wait_cnt <= 2'd1;
                    side_rx <= rx_g;
                end
                WAIT: if (rsp) begin
                    msg_cnt <= msg_cnt == HOP_LAST ? '0 : msg_cnt + 8'd1;
                    state <= msg_cnt == HOP_LAST ? HOP : RUN;
                end else wait_cnt <= wait_cnt + 2'd1;
                HOP: begin
                    page <= next_page(page, bus.hop_key);
                    page_hop_q <= 1'b1;
                    state <= RUN;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_can_id_hopping_scheduler.sv
// tb_can_id_hopping_scheduler: random-stimulus bench with a transaction-level reference model and table-pair emulation
module tb_can_id_hopping_scheduler;
    localparam int N = 16;
    localparam int HI = 4;
    localparam int L = 2;
    logic clk = 1'b0;
    logic rest_bit_n;
    always #5 clk = ~clk;
    can_id_hopping_scheduler_if bus ();
    can_id_hopping_scheduler #(.NUM_IDS(N), .HOP_INTERVAL(HI), .LOOKUP_LAT(L)) dut (
        .clk(clk), .rest_bit_n(rest_bit_n), .bus(bus)
    );
    int n_checks = 0, n_fail = 0, cyc = 0;
    function automatic logic [10:0] tbl_fn(input logic [10:0] id, input logic [3:0] pg, input bit rx);
        return id ^ {pg, ~pg, rx ? 3'd5 : 3'd2};
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask
    // table pair: result appears LOOKUP_LAT cycles after the strobe, random noise otherwise
    logic [10:0] p1 [L];
    logic [10:0] p2 [L];
    always @(posedge clk) begin
        p1[0] <= bus.tbl_send_bit ? tbl_fn(bus.tbl_id, bus.tbl_page, 1'b0) : 11'($urandom);
        p2[0] <= bus.tbl_receive_bit ? tbl_fn(bus.tbl_id, bus.tbl_page, 1'b1) : 11'($urandom);
        p1[1] <= p1[0];
        p2[1] <= p2[0];
    end
    assign bus.tbl_id_o_1 = p1[L-1];
    assign bus.tbl_id_o_2 = p2[L-1];
    // reference model state
    int m_loaded, m_busy, m_msgs;
    bit m_prio_rx, m_busy_rx, m_hop_pend, m_hop_flag;
    logic [3:0] m_page;
    logic [10:0] m_data;
    bit e_tx_gnt, e_rx_gnt, e_cfg_acc;
    // observation logs from the DUT for literal checks
    int gnt_side[$];
    int gnt_id[$];
    int page_log[$];
    int we_cnt, last_we, first_tx_gnt = -1, first_tx_rsp = -1;
    bit done_seen;
    initial begin : compare
        bit e_ready, e_done, e_we, e_txv, e_rxv, e_hop, pick_rx;
        logic [10:0] e_id, e_txd, e_rxd;
        logic [3:0] e_page;
        forever begin
            @(negedge clk);
            cyc++;
            {e_ready, e_done, e_we, e_txv, e_rxv, e_hop, e_tx_gnt, e_rx_gnt, e_cfg_acc} = '0;
            e_id = '0; e_txd = '0; e_rxd = '0;
            e_page = m_page;
            if (!rest_bit_n) begin
                e_page = '0;
                m_loaded = 0; m_busy = 0; m_msgs = 0; m_page = '0;
                m_prio_rx = 0; m_hop_pend = 0; m_hop_flag = 0;
                we_cnt = 0; done_seen = 0;
            end else begin
                e_hop = m_hop_flag;
                m_hop_flag = 0;
                if (m_loaded < N) begin
                    e_ready = 1;
                    if (bus.cfg_valid) begin
                        e_cfg_acc = 1; e_we = 1; e_id = bus.cfg_id; m_loaded++;
                    end
                end else begin
                    e_done = 1;
                    if (m_hop_pend) begin
                        m_page = m_page + (bus.hop_key | 4'h1);
                        m_hop_pend = 0; m_hop_flag = 1;
                    end else if (m_busy > 0) begin
                        if (m_busy == 1) begin
                            if (m_busy_rx) begin e_rxv = 1; e_rxd = m_data; end
                            else begin e_txv = 1; e_txd = m_data; end
                            m_msgs++;
                            if (m_msgs == HI) begin m_msgs = 0; m_hop_pend = 1; end
                        end
                        m_busy--;
                    end else if (bus.tx_req || bus.rx_req) begin
                        pick_rx = bus.rx_req && (!bus.tx_req || m_prio_rx);
                        e_id = pick_rx ? bus.rx_phys_id : bus.tx_app_id;
                        e_tx_gnt = !pick_rx; e_rx_gnt = pick_rx;
                        m_prio_rx = !pick_rx; m_busy = L; m_busy_rx = pick_rx;
                        m_data = tbl_fn(e_id, m_page, pick_rx);
                    end
                end
            end
            chk("cfg_ready", bus.cfg_ready, e_ready);
            chk("cfg_done", bus.cfg_done, e_done);
            chk("tbl_we", bus.tbl_we, e_we);
            chk("tx_gnt", bus.tx_gnt, e_tx_gnt);
            chk("rx_gnt", bus.rx_gnt, e_rx_gnt);
            chk("tbl_send_bit", bus.tbl_send_bit, e_tx_gnt);
            chk("tbl_receive_bit", bus.tbl_receive_bit, e_rx_gnt);
            chk("tbl_id", bus.tbl_id, e_id);
            chk("tx_rsp_valid", bus.tx_rsp_valid, e_txv);
            chk("tx_phys_id", bus.tx_phys_id, e_txd);
            chk("rx_rsp_valid", bus.rx_rsp_valid, e_rxv);
            chk("rx_app_id", bus.rx_app_id, e_rxd);
            chk("tbl_page", bus.tbl_page, e_page);
            chk("page_hop", bus.page_hop, e_hop);
            if (bus.tbl_we) begin
                chk("load_id_seq", bus.tbl_id, 32'h100 + we_cnt);
                we_cnt++; last_we = cyc;
            end
            if (bus.cfg_done && !done_seen) begin
                done_seen = 1;
                chk("done_after_16", we_cnt, 16);
                chk("done_next_cycle", cyc - last_we, 1);
            end
            if (bus.tx_gnt || bus.rx_gnt) begin
                gnt_side.push_back(int'(bus.rx_gnt));
                gnt_id.push_back(int'(bus.tbl_id));
                if (bus.tx_gnt && first_tx_gnt < 0) first_tx_gnt = cyc;
            end
            if (bus.tx_rsp_valid && first_tx_rsp < 0) first_tx_rsp = cyc;
            if (bus.page_hop) page_log.push_back(int'(bus.tbl_page));
        end
    end
    bit auto_req = 0;
    bit rand_key = 0;
    task automatic step();
        @(posedge clk);
        #1;
        if (auto_req) begin
            if (bus.tx_req && e_tx_gnt) bus.tx_req = 0;
            if (!bus.tx_req && $urandom_range(0, 2) == 0) begin bus.tx_req = 1; bus.tx_app_id = 11'($urandom); end
            if (bus.rx_req && e_rx_gnt) bus.rx_req = 0;
            if (!bus.rx_req && $urandom_range(0, 2) == 0) begin bus.rx_req = 1; bus.rx_phys_id = 11'($urandom); end
        end
        if (rand_key) bus.hop_key = 4'($urandom);
        bus.cfg_valid = 1'($urandom_range(0, 1));
        bus.cfg_id = m_loaded < N ? 11'(32'h100 + m_loaded) : 11'($urandom);
    endtask
    task automatic load_all();
        int b = 0;
        while (m_loaded < N && b < 300) begin step(); b++; end
        if (m_loaded < N) chk("load_timeout", 0, 1);
    endtask
    initial begin : main
        int b, ntx;
        rest_bit_n = 0;
        bus.cfg_valid = 0; bus.cfg_id = '0; bus.hop_key = 4'h6;
        bus.tx_req = 1; bus.tx_app_id = 11'h105;
        bus.rx_req = 1; bus.rx_phys_id = 11'h2AA;
        repeat (3) @(posedge clk);
        #1 rest_bit_n = 1;
        @(negedge clk);
        chk("reset_cfg_ready", bus.cfg_ready, 1);
        chk("reset_cfg_done", bus.cfg_done, 0);
        chk("reset_page", bus.tbl_page, 0);
        chk("no_gnt_in_load", bus.tx_gnt | bus.rx_gnt, 0);
        load_all();
        ntx = 0; b = 0;
        while (gnt_side.size() < 3 && b < 60) begin
            step(); b++;
            if (bus.tx_req && e_tx_gnt) begin
                ntx++;
                if (ntx == 1) bus.tx_app_id = 11'h106; else bus.tx_req = 0;
            end
            if (bus.rx_req && e_rx_gnt) bus.rx_req = 0;
        end
        if (gnt_side.size() < 3) chk("conflict_timeout", 0, 1);
        else begin
            chk("gnt0_side_tx", gnt_side[0], 0);
            chk("gnt0_id", gnt_id[0], 32'h105);
            chk("gnt1_side_rx", gnt_side[1], 1);
            chk("gnt1_id", gnt_id[1], 32'h2AA);
            chk("gnt2_side_tx", gnt_side[2], 0);
            chk("gnt2_id", gnt_id[2], 32'h106);
        end
        repeat (L + 1) step();
        chk("tx_latency", first_tx_rsp - first_tx_gnt, L);
        auto_req = 1; b = 0;
        while (page_log.size() < 16 && b < 4000) begin step(); b++; end
        if (page_log.size() < 16) chk("hop_timeout", 0, 1);
        else begin
            chk("hop1_page", page_log[0], 7);
            chk("hop2_page", page_log[1], 14);
            chk("hop3_page", page_log[2], 5);
            chk("hop16_page", page_log[15], 0);
        end
        rand_key = 1;
        repeat (400) step();
        b = 0;
        while (m_busy == 0 && b < 50) begin step(); b++; end
        if (m_busy == 0) chk("wait_timeout", 0, 1);
        rest_bit_n = 0;
        @(negedge clk);
        chk("rst_page", bus.tbl_page, 0);
        chk("rst_no_rsp", bus.tx_rsp_valid | bus.rx_rsp_valid, 0);
        step();
        rest_bit_n = 1;
        @(negedge clk);
        chk("rst_release_ready", bus.cfg_ready, 1);
        chk("rst_release_done", bus.cfg_done, 0);
        load_all();
        repeat (300) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
